ad3542_spi_writer: RTL and testbench
====================================

# ad3542_spi_writer

Downstream stage of the waveform sequencer on the zedboard-ad3542 board. It accepts 16-bit DAC codes from the sequencer's `data_out`/`valid_out` stream and buffers them in a small FIFO. It serializes each code as one 24-bit AD3542 register-write frame on a mode-0 SPI bus. The sequencer has no back-pressure, so this block absorbs bursts and flags any sample it has to drop.

## Interface
- `CLK_HALF`, default 4: clk cycles per SCLK half-period, ≥1; SCLK = clk/(2·CLK_HALF).
- `GAP_CYCLES`, default 4: minimum extra cycles with cs_n high between frames, ≥0.
- `REG_ADDR`, default 7'h2A: 7-bit DAC input register address placed in the instruction byte.
- `FIFO_DEPTH`, default 16: sample FIFO depth, power of two, ≥2.
- `clk` in 1: system clock.
- `reset` in 1: synchronous, active-high.
- `data_in` in 16: DAC code from sequencer.
- `valid_in` in 1: one-cycle qualifier for `data_in`; may assert on any cycle, with no ready.
- `clear_overflow` in 1: clears `overflow`.
- `busy` out 1: FSM not in IDLE or FIFO non-empty.
- `overflow` out 1: sticky; a sample was dropped.
- `fifo_level` out $clog2(FIFO_DEPTH)+1: current FIFO occupancy.
- `spi_cs_n` out 1: chip select, active low.
- `spi_sclk` out 1: SPI clock, idles low.
- `spi_sdo` out 1: serial data, MSB first.

## Operation
- **Frame**: 24 bits, sent MSB first. Bit 23 = 0 (write). Bits 22:16 = REG_ADDR. Bits 15:0 = sample.
- **FSM states**: IDLE → CS_SETUP → SHIFT → CS_HOLD → CS_GAP → IDLE.
- **IDLE**: when the FIFO is non-empty, pop the head, load the shift register, and go to CS_SETUP. When the FIFO is empty, stay in IDLE.
- **CS_SETUP**: cs_n=0, sclk=0, sdo=bit 23. Lasts CLK_HALF cycles.
- **SHIFT**: for each bit, sclk is high for CLK_HALF cycles, then low for CLK_HALF cycles.
  - sdo advances to the next bit on the falling edge of sclk.
  - After the high phase of bit 0, sclk falls and the FSM enters CS_HOLD.
- **CS_HOLD**: sclk=0, cs_n=0 for CLK_HALF cycles, then cs_n=1.
- **CS_GAP**: cs_n=1 for GAP_CYCLES cycles, then IDLE.
- **FIFO push**: on `valid_in` when not full. A push and a pop in the same cycle are both honoured, including when the FIFO is full.
- **Drop rule**: `valid_in` while full with no same-cycle pop drops the sample and sets `overflow`.
- **overflow**: clears on `clear_overflow`. If set and clear occur in the same cycle, set wins.
- **Reset**, including mid-frame: on the next edge cs_n=1, sclk=0, sdo=0, busy=0, overflow=0, fifo_level=0, FSM=IDLE. The FIFO is emptied and the partial frame is abandoned, not resumed.

## Timing
- Reset values: spi_cs_n=1, spi_sclk=0, spi_sdo=0, busy=0, overflow=0, fifo_level=0.
- Latency from an accepted `valid_in` into an idle, empty block to cs_n falling: 2 cycles (push cycle, then the IDLE pop cycle).
- cs_n is low for exactly 49·CLK_HALF cycles per frame.
- SCLK has exactly 24 rising edges per frame. sdo is stable for at least CLK_HALF cycles before each rising edge.
- Frame period is 49·CLK_HALF + GAP_CYCLES + 1 cycles. With defaults: 201 cycles.
- `fifo_level` updates the cycle after a push or pop. A simultaneous push and pop leaves the level unchanged.
- `busy` is registered and follows FSM/FIFO state with 1-cycle latency.

## Structure
- Shared package `ad3542_pkg`:
  - `AD3542_FRAME_BITS` = 24
  - `AD3542_WRITE_BIT` = 1'b0
  - FSM state enum
- Sub-module `sync_fifo`:
  - parameters WIDTH=16, DEPTH
  - ports: push, push_data, pop, pop_data, full, empty, level
  - behaviour: first-word-fall-through, so the head is valid whenever not empty
  - reusable elsewhere on the board
- The top level holds the FSM, a phase counter of $clog2(CLK_HALF)+1 bits, a 5-bit bit counter, and a 24-bit shift register.

## Test plan
- **Reset**: hold reset 5 cycles → all outputs at reset values; no sclk edges.
- **Single frame**: CLK_HALF=2, GAP_CYCLES=4, data_in=16'hA5C3, one valid pulse → one frame.
  - Capturing sdo on sclk rising edges yields 24'h2AA5C3.
  - cs_n is low 98 cycles; busy drops within 2 cycles after CS_GAP ends.
- **Burst at sequencer rate**: 17 samples, valid every 2 cycles, defaults → 17 frames in order (first popped immediately, 16 buffered).
  - overflow stays 0; fifo_level peaks at 16.
- **Overflow**: 18 samples at 2-cycle spacing → samples 1–17 transmitted; sample 18 dropped; overflow=1.
  - A clear_overflow pulse → overflow=0 next cycle.
- **Full with simultaneous push/pop**: FIFO full and a push coincides with the IDLE pop → push accepted; level stays 16; no overflow.
- **Reset mid-frame**: assert reset at SCLK rising edge 10 with 3 samples queued → next cycle cs_n=1, fifo_level=0.
  - Afterward a new sample 16'h0001 produces a clean frame 24'h2A0001.

Source files
------------

// File: rtl/ad3542_pkg.sv
// Shared definitions for the AD3542 SPI writer: frame layout and FSM states.
package ad3542_pkg;

  localparam int   AD3542_FRAME_BITS = 24;
  localparam logic AD3542_WRITE_BIT  = 1'b0;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CS_SETUP,
    ST_SHIFT,
    ST_CS_HOLD,
    ST_CS_GAP
  } ad3542_state_t;

  function automatic logic [AD3542_FRAME_BITS-1:0] build_frame(input logic [6:0]  addr,
                                                               input logic [15:0] code);
    return {AD3542_WRITE_BIT, addr, code};
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// First-word-fall-through synchronous FIFO; push while full is accepted only alongside a pop.
module sync_fifo #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     push,
  input  logic [WIDTH-1:0]         push_data,
  input  logic                     pop,
  output logic [WIDTH-1:0]         pop_data,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   level
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign level    = wr_ptr - rd_ptr;
  assign full     = (level == (AW+1)'(DEPTH));
  assign empty    = (level == '0);
  assign pop_data = mem[rd_ptr[AW-1:0]];
  assign do_pop   = pop && !empty;
  assign do_push  = push && (!full || do_pop);

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + (AW+1)'(1);
      if (do_pop)  rd_ptr <= rd_ptr + (AW+1)'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr[AW-1:0]] <= push_data;
  end

endmodule

// File: rtl/ad3542_spi_writer.sv
// Buffers sequencer DAC codes and writes each one to the AD3542 as a 24-bit mode-0 SPI frame.
module ad3542_spi_writer
  import ad3542_pkg::*;
#(
  parameter int         CLK_HALF   = 4,
  parameter int         GAP_CYCLES = 4,
  parameter logic [6:0] REG_ADDR   = 7'h2A,
  parameter int         FIFO_DEPTH = 16
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic [15:0]                   data_in,
  input  logic                          valid_in,
  input  logic                          clear_overflow,
  output logic                          busy,
  output logic                          overflow,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
  output logic                          spi_cs_n,
  output logic                          spi_sclk,
  output logic                          spi_sdo
);

  localparam int                PH_W     = $clog2(CLK_HALF) + 1;
  localparam logic [PH_W-1:0]   PH_LAST  = PH_W'(CLK_HALF - 1);
  localparam int                GAP_W    = $clog2(GAP_CYCLES + 1) + 1;
  localparam logic [GAP_W-1:0]  GAP_LAST = GAP_W'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);
  localparam logic [4:0]        BIT_TOP  = 5'(AD3542_FRAME_BITS - 1);

  ad3542_state_t                  state, state_next;
  logic [PH_W-1:0]                phase, phase_next;
  logic [4:0]                     bit_cnt, bit_cnt_next;
  logic [GAP_W-1:0]               gap_cnt, gap_next;
  logic                           sclk_q, sclk_next;
  logic [AD3542_FRAME_BITS-1:0]   shreg, shreg_next;
  logic                           cs_n_q, sdo_q, busy_q, overflow_q;
  logic                           frame_active_next;
  logic                           fifo_pop, fifo_full, fifo_empty;
  logic [15:0]                    fifo_head;
  logic                           drop;

  sync_fifo #(
    .WIDTH (16),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (valid_in),
    .push_data (data_in),
    .pop       (fifo_pop),
    .pop_data  (fifo_head),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .level     (fifo_level)
  );

  always_comb begin
    state_next   = state;
    phase_next   = phase;
    bit_cnt_next = bit_cnt;
    gap_next     = gap_cnt;
    sclk_next    = sclk_q;
    shreg_next   = shreg;
    fifo_pop     = 1'b0;
    unique case (state)
      ST_IDLE: begin
        if (!fifo_empty) begin
          fifo_pop   = 1'b1;
          shreg_next = build_frame(REG_ADDR, fifo_head);
          phase_next = '0;
          state_next = ST_CS_SETUP;
        end
      end
      ST_CS_SETUP: begin
        if (phase == PH_LAST) begin
          phase_next   = '0;
          sclk_next    = 1'b1;
          bit_cnt_next = BIT_TOP;
          state_next   = ST_SHIFT;
        end else begin
          phase_next = phase + PH_W'(1);
        end
      end
      ST_SHIFT: begin
        // The last bit ends on its high phase; sclk falls as the hold phase starts.
        if (phase == PH_LAST) begin
          phase_next = '0;
          if (sclk_q) begin
            sclk_next = 1'b0;
            if (bit_cnt == 5'd0) begin
              state_next = ST_CS_HOLD;
            end else begin
              shreg_next   = shreg << 1;
              bit_cnt_next = bit_cnt - 5'd1;
            end
          end else begin
            sclk_next = 1'b1;
          end
        end else begin
          phase_next = phase + PH_W'(1);
        end
      end
      ST_CS_HOLD: begin
        if (phase == PH_LAST) begin
          phase_next = '0;
          gap_next   = '0;
          state_next = (GAP_CYCLES == 0) ? ST_IDLE : ST_CS_GAP;
        end else begin
          phase_next = phase + PH_W'(1);
        end
      end
      ST_CS_GAP: begin
        if (gap_cnt == GAP_LAST) state_next = ST_IDLE;
        else                     gap_next   = gap_cnt + GAP_W'(1);
      end
      default: state_next = ST_IDLE;
    endcase
  end

  assign frame_active_next = (state_next == ST_CS_SETUP) || (state_next == ST_SHIFT) ||
                             (state_next == ST_CS_HOLD);
  assign drop = valid_in && fifo_full && !fifo_pop;

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= ST_IDLE;
      phase      <= '0;
      bit_cnt    <= '0;
      gap_cnt    <= '0;
      sclk_q     <= 1'b0;
      cs_n_q     <= 1'b1;
      sdo_q      <= 1'b0;
      busy_q     <= 1'b0;
      overflow_q <= 1'b0;
    end else begin
      state      <= state_next;
      phase      <= phase_next;
      bit_cnt    <= bit_cnt_next;
      gap_cnt    <= gap_next;
      sclk_q     <= sclk_next;
      cs_n_q     <= !frame_active_next;
      sdo_q      <= frame_active_next && shreg_next[AD3542_FRAME_BITS-1];
      busy_q     <= (state != ST_IDLE) || !fifo_empty;
      overflow_q <= drop ? 1'b1 : (clear_overflow ? 1'b0 : overflow_q);
    end
  end

  always_ff @(posedge clk) begin
    shreg <= shreg_next;
  end

  assign spi_cs_n = cs_n_q;
  assign spi_sclk = sclk_q;
  assign spi_sdo  = sdo_q;
  assign busy     = busy_q;
  assign overflow = overflow_q;

endmodule

// File: tb/tb_ad3542_spi_writer.sv
// Bench for ad3542_spi_writer: frame scoreboard plus vector table and burst/overflow/reset sequences.
module tb_ad3542_spi_writer;

  localparam int CH  = 2;
  localparam int GAP = 4;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [15:0] data_in = '0;
  logic        valid_in = 1'b0;
  logic        clear_overflow = 1'b0;
  logic        busy, overflow, spi_cs_n, spi_sclk, spi_sdo;
  logic [4:0]  fifo_level;

  always #5 clk = ~clk;

  ad3542_spi_writer #(
    .CLK_HALF   (CH),
    .GAP_CYCLES (GAP),
    .REG_ADDR   (7'h2A),
    .FIFO_DEPTH (16)
  ) dut (
    .clk            (clk),
    .reset          (reset),
    .data_in        (data_in),
    .valid_in       (valid_in),
    .clear_overflow (clear_overflow),
    .busy           (busy),
    .overflow       (overflow),
    .fifo_level     (fifo_level),
    .spi_cs_n       (spi_cs_n),
    .spi_sclk       (spi_sclk),
    .spi_sdo        (spi_sdo)
  );

  typedef struct {
    logic [15:0] data;
    logic [23:0] frame;
  } vec_t;

  int          checks = 0;
  int          errors = 0;
  logic [23:0] exp_q[$];
  logic [23:0] cap = '0;
  int          nbits = 0;
  int          sclk_rises = 0;
  int          abort_req = 0;

  function automatic void check(input string name, input logic [31:0] actual,
                                input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("FAIL %s: got %0h, required %0h", name, actual, expected);
    end
  endfunction

  initial begin
    forever begin
      @(posedge spi_sclk);
      sclk_rises++;
      if (spi_cs_n === 1'b0) begin
        cap = {cap[22:0], spi_sdo};
        nbits++;
      end
    end
  end

  // Frame monitor: a cs_n rising edge closes a frame and is scored against the queue.
  initial begin
    int   cs_low = 0;
    int   nbits_base = 0;
    int   abort_seen = 0;
    logic cs_prev = 1'b1;
    forever begin
      @(negedge clk);
      if (spi_cs_n === 1'b0) cs_low++;
      if (cs_prev === 1'b0 && spi_cs_n === 1'b1) begin
        if (abort_req != abort_seen) begin
          abort_seen++;
        end else if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_frame: got %06h, required no frame", cap);
        end else begin
          check("frame_data", cap, exp_q.pop_front());
          check("frame_bits", nbits - nbits_base, 24);
          check("cs_low_cycles", cs_low, 49 * CH);
        end
        nbits_base = nbits;
        cs_low = 0;
      end
      cs_prev = spi_cs_n;
    end
  end

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic send(input logic [15:0] d);
    data_in  = d;
    valid_in = 1'b1;
    @(negedge clk);
    valid_in = 1'b0;
  endtask

  task automatic wait_cs_high();
    int n = 0;
    while (spi_cs_n !== 1'b1 && n < 300) begin
      @(negedge clk);
      n++;
    end
    check("cs_high_reached", spi_cs_n, 1);
  endtask

  task automatic wait_drain();
    int n = 0;
    while ((exp_q.size() != 0 || busy !== 1'b0) && n < 5000) begin
      @(negedge clk);
      n++;
    end
    check("drain_queue_empty", exp_q.size(), 0);
    check("drain_busy", busy, 0);
  endtask

  initial begin
    vec_t        vecs[5];
    int          peak;
    int          n;
    logic [15:0] d;

    vecs[0] = '{16'hA5C3, 24'h2AA5C3};
    vecs[1] = '{16'h0000, 24'h2A0000};
    vecs[2] = '{16'hFFFF, 24'h2AFFFF};
    vecs[3] = '{16'h8001, 24'h2A8001};
    vecs[4] = '{16'h1234, 24'h2A1234};

    reset = 1'b1;
    repeat (5) @(negedge clk);
    check("reset_cs_n", spi_cs_n, 1);
    check("reset_sclk", spi_sclk, 0);
    check("reset_sdo", spi_sdo, 0);
    check("reset_busy", busy, 0);
    check("reset_overflow", overflow, 0);
    check("reset_level", fifo_level, 0);
    check("reset_sclk_edges", sclk_rises, 0);
    reset = 1'b0;
    repeat (2) @(negedge clk);

    for (int i = 0; i < 5; i++) begin
      exp_q.push_back(vecs[i].frame);
      send(vecs[i].data);
      check("cs_n_after_push", spi_cs_n, 1);
      @(negedge clk);
      check("cs_n_latency", spi_cs_n, 0);
      if (i == 0) begin
        wait_cs_high();
        n = 0;
        while (busy !== 1'b0 && n < 20) begin
          @(negedge clk);
          n++;
        end
        check("busy_drop_cycles", n, GAP + 1);
      end
      wait_drain();
      @(negedge clk);
    end

    // Burst of 17 at two-cycle spacing, then an 18th sample that must be dropped.
    peak = 0;
    for (int k = 0; k < 17; k++) begin
      d = 16'($urandom_range(0, 65535));
      exp_q.push_back({8'h2A, d});
      send(d);
      if (int'(fifo_level) > peak) peak = int'(fifo_level);
      @(negedge clk);
      if (int'(fifo_level) > peak) peak = int'(fifo_level);
    end
    check("burst_overflow_clear", overflow, 0);
    check("burst_peak_level", peak, 16);
    send(16'hDEAD);
    check("overflow_set", overflow, 1);
    check("level_after_drop", fifo_level, 16);
    data_in = 16'hBEEF;
    valid_in = 1'b1;
    clear_overflow = 1'b1;
    @(negedge clk);
    valid_in = 1'b0;
    clear_overflow = 1'b0;
    check("overflow_set_wins", overflow, 1);
    clear_overflow = 1'b1;
    @(negedge clk);
    clear_overflow = 1'b0;
    check("overflow_cleared", overflow, 0);

    // Push landing on the IDLE pop cycle while full.
    wait_cs_high();
    repeat (GAP) @(negedge clk);
    check("level_full_before_pop", fifo_level, 16);
    exp_q.push_back(24'h2A5A5A);
    send(16'h5A5A);
    check("level_push_pop_full", fifo_level, 16);
    check("overflow_push_pop_full", overflow, 0);
    check("cs_n_next_frame", spi_cs_n, 0);
    wait_drain();
    @(negedge clk);

    // Reset on the tenth SCLK rising edge with three samples still queued.
    n = sclk_rises;
    send(16'h1111);
    @(negedge clk);
    send(16'h2222);
    @(negedge clk);
    send(16'h3333);
    @(negedge clk);
    send(16'h4444);
    begin
      int w = 0;
      while (sclk_rises - n < 10 && w < 500) begin
        @(negedge clk);
        w++;
      end
    end
    check("sclk_rise_count_mid", sclk_rises - n, 10);
    check("level_before_reset", fifo_level, 3);
    abort_req++;
    reset = 1'b1;
    @(negedge clk);
    check("midreset_cs_n", spi_cs_n, 1);
    check("midreset_sclk", spi_sclk, 0);
    check("midreset_sdo", spi_sdo, 0);
    check("midreset_level", fifo_level, 0);
    check("midreset_busy", busy, 0);
    reset = 1'b0;
    repeat (3) @(negedge clk);
    check("post_reset_idle_cs_n", spi_cs_n, 1);
    exp_q.push_back(24'h2A0001);
    send(16'h0001);
    wait_drain();
    repeat (10) @(negedge clk);
    check("final_queue_empty", exp_q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
